// File: rtl/sample_window_loader_pkg.sv
// Shared definitions for the eight-sample window loader and its downstream adder:
// sample width, window depth, FSM encoding and handoff-counter width.
package sample_window_loader_pkg;

  localparam int SWL_W       = 12;
  localparam int SWL_N       = 8;
  localparam int WIN_COUNT_W = 8;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } swl_state_e;

endpackage

// File: rtl/sample_window_loader.sv
// Collects eight consecutive signed samples into a registered slot bank (n0 = oldest)
// and holds them for a parallel adder until the window is consumed.
module sample_window_loader
  import sample_window_loader_pkg::*;
#(
  parameter int W = SWL_W,
  parameter int N = SWL_N
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [W-1:0]           in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   clear,
  output logic [W-1:0]           n0,
  output logic [W-1:0]           n1,
  output logic [W-1:0]           n2,
  output logic [W-1:0]           n3,
  output logic [W-1:0]           n4,
  output logic [W-1:0]           n5,
  output logic [W-1:0]           n6,
  output logic [W-1:0]           n7,
  output logic                   win_valid,
  input  logic                   win_ready,
  output logic [WIN_COUNT_W-1:0] win_count
);

  swl_state_e             state_q, state_d;
  logic [2:0]             idx_q, idx_d;
  logic [W-1:0]           slot_q [N];
  logic [W-1:0]           slot_d [N];
  logic [WIN_COUNT_W-1:0] count_q, count_d;

  // Next-state, slot write and handshake decode; clear and reset suppress both handshakes.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    slot_d    = slot_q;
    count_d   = count_q;
    in_ready  = 1'b0;
    win_valid = 1'b0;
    if (!rst_n || clear) begin
      state_d = FILL;
      idx_d   = 3'd0;
    end else begin
      case (state_q)
        FILL: begin
          in_ready = 1'b1;
          if (in_valid) begin
            slot_d[idx_q] = in_data;
            idx_d         = idx_q + 3'd1;
            if (idx_q == 3'd7) begin
              state_d = HOLD;
            end else begin
              state_d = FILL;
            end
          end else begin
            idx_d = idx_q;
          end
        end
        HOLD: begin
          win_valid = 1'b1;
          in_ready  = win_ready;
          if (win_ready) begin
            // A sample arriving with the handoff starts the next window without a bubble.
            count_d = count_q + WIN_COUNT_W'(1);
            state_d = FILL;
            if (in_valid) begin
              slot_d[0] = in_data;
              idx_d     = 3'd1;
            end else begin
              idx_d     = 3'd0;
            end
          end else begin
            state_d = HOLD;
          end
        end
        default: begin
          state_d = FILL;
          idx_d   = 3'd0;
        end
      endcase
    end
  end

  // State, index, slot bank and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FILL;
      idx_q   <= 3'd0;
      count_q <= '0;
      for (int i = 0; i < N; i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      slot_q  <= slot_d;
    end
  end

  assign n0        = slot_q[0];
  assign n1        = slot_q[1];
  assign n2        = slot_q[2];
  assign n3        = slot_q[3];
  assign n4        = slot_q[4];
  assign n5        = slot_q[5];
  assign n6        = slot_q[6];
  assign n7        = slot_q[7];
  assign win_count = count_q;

endmodule

// File: tb/tb_sample_window_loader.sv
// Directed bench for sample_window_loader: expected windows are queued as stimulus
// is issued and a negedge monitor checks every handoff against the queue.
module tb_sample_window_loader;
  import sample_window_loader_pkg::*;

  localparam int W = SWL_W;

  typedef struct {
    logic [8*W-1:0]  win;
    logic [W+2:0]    sum;
    logic [7:0]      cnt;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         clear = 1'b0;
  logic [W-1:0] n0, n1, n2, n3, n4, n5, n6, n7;
  logic         win_valid;
  logic         win_ready = 1'b0;
  logic [7:0]   win_count;

  int   tests = 0;
  int   fails = 0;
  int   stalls = 0;
  int   exp_count = 0;
  exp_t sb_q[$];
  exp_t mon_e;

  sample_window_loader #(.W(W), .N(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .clear(clear),
    .n0(n0), .n1(n1), .n2(n2), .n3(n3), .n4(n4), .n5(n5), .n6(n6), .n7(n7),
    .win_valid(win_valid), .win_ready(win_ready), .win_count(win_count)
  );

  always #5 clk = ~clk;

  function automatic logic [8*W-1:0] dut_win();
    return {n0, n1, n2, n3, n4, n5, n6, n7};
  endfunction

  function automatic logic [W+2:0] win_sum(input logic [8*W-1:0] w);
    logic [W+2:0] s = '0;
    logic [W-1:0] d;
    for (int i = 0; i < 8; i++) begin
      d = w[8*W-1-W*i -: W];
      s = s + {{3{d[W-1]}}, d};
    end
    return s;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Offer one sample and wait (bounded) until it is accepted.
  task automatic send(input logic [W-1:0] d);
    int t = 0;
    in_valid = 1'b1;
    in_data  = d;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      stalls++;
      t++;
      if (t > 50) begin
        tests++;
        fails++;
        $display("FAIL send_timeout: in_ready stuck at 0 for data %0h", d);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_win(input logic [8*W-1:0] w, input logic [W+2:0] sum);
    exp_t e;
    e.win = w;
    e.sum = sum;
    e.cnt = 8'(exp_count);
    sb_q.push_back(e);
    exp_count = (exp_count + 1) % 256;
    for (int i = 0; i < 8; i++) send(w[8*W-1-W*i -: W]);
  endtask

  // Handoff monitor: each consumed window must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && win_valid && win_ready) begin
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_window: got %0h expected none", dut_win());
      end else begin
        mon_e = sb_q.pop_front();
        check("window", 128'(dut_win()), 128'(mon_e.win));
        check("adder_sum", 128'(win_sum(dut_win())), 128'(mon_e.sum));
        check("count_at_handoff", 128'(win_count), 128'(mon_e.cnt));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8*W-1:0] w;
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_in_ready", 128'(in_ready), 128'(0));
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_win_valid", 128'(win_valid), 128'(0));
    check("reset_slots", 128'(dut_win()), 128'(0));
    check("reset_count", 128'(win_count), 128'(0));
    check("post_reset_in_ready", 128'(in_ready), 128'(1));
    @(posedge clk);
    #1;

    // Eight 0xFFF samples, sum -8
    win_ready = 1'b1;
    send_win({8{12'hFFF}}, 15'h7FF8);
    @(negedge clk);
    check("latency_win_valid", 128'(win_valid), 128'(1));
    @(posedge clk);
    #1;
    check("win_valid_one_cycle", 128'(win_valid), 128'(0));
    check("count_after_first", 128'(win_count), 128'(1));

    // Back-to-back windows of max positive then max negative
    stalls = 0;
    send_win({8{12'h7FF}}, 15'h3FF8);
    send_win({8{12'h800}}, 15'h4000);
    check("b2b_no_stall", 128'(stalls), 128'(0));
    @(posedge clk);
    #1;

    // Alternating samples with a 5-cycle downstream stall
    win_ready = 1'b0;
    w = {12'h001, 12'hFFF, 12'h001, 12'hFFF, 12'h001, 12'hFFF, 12'h001, 12'hFFF};
    send_win(w, 15'h0000);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("stall_in_ready", 128'(in_ready), 128'(0));
      check("stall_win_valid", 128'(win_valid), 128'(1));
      check("stall_slots", 128'(dut_win()), 128'(w));
      @(posedge clk);
      #1;
    end
    win_ready = 1'b1;
    @(posedge clk);
    #1;

    // Clear aborts a partial window without touching the count
    for (int i = 0; i < 3; i++) send(12'h123);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 12'h7AB;
    @(negedge clk);
    check("clear_in_ready", 128'(in_ready), 128'(0));
    check("clear_win_valid", 128'(win_valid), 128'(0));
    @(posedge clk);
    #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    check("clear_count", 128'(win_count), 128'(4));
    send_win({8{12'h001}}, 15'h0008);
    @(posedge clk);
    #1;

    // Reset while holding a window
    win_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(12'h055);
    @(negedge clk);
    check("hold_before_reset", 128'(win_valid), 128'(1));
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("reset_hold_in_ready", 128'(in_ready), 128'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    exp_count = 0;
    @(negedge clk);
    check("rst_hold_win_valid", 128'(win_valid), 128'(0));
    check("rst_hold_slots", 128'(dut_win()), 128'(0));
    check("rst_hold_count", 128'(win_count), 128'(0));
    check("rst_hold_in_ready", 128'(in_ready), 128'(1));
    @(posedge clk);
    #1;
    win_ready = 1'b1;
    send_win({8{12'h0AA}}, 15'h0550);
    @(posedge clk);
    #1;

    // 256 further handoffs: counter passes 255 -> 0 and ends at 1
    for (int k = 0; k < 256; k++) begin
      for (int i = 0; i < 8; i++) w[8*W-1-W*i -: W] = 12'((k * 37 + i * 517) & 12'hFFF);
      send_win(w, win_sum(w));
    end
    @(posedge clk);
    #1;
    check("count_wrapped", 128'(win_count), 128'(1));
    repeat (3) @(posedge clk);
    check("scoreboard_empty", 128'(sb_q.size()), 128'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sample_window_loader.md
SAMPLE_WINDOW_LOADER -- requirements
Module: sample_window_loader

Interface
REQ-001 SHALL have parameter W, default 12: signed sample width in bits.
REQ-002 SHALL have parameter N, default 8: samples per window, fixed at 8, matching the eight adder operand ports.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port in_data, input, W bits: two's-complement sample stream.
REQ-006 SHALL have port in_valid, input, 1 bit: in_data is valid this cycle.
REQ-007 SHALL have port in_ready, output, 1 bit: the block accepts in_data this cycle.
REQ-008 SHALL have port clear, input, 1 bit: synchronous abort of the current window.
REQ-009 SHALL have ports n0..n7, output, W bits each: window slots, registered, n0 = oldest sample, feeding the parallel signed adder.
REQ-010 SHALL have port win_valid, output, 1 bit: n0..n7 hold a complete window.
REQ-011 SHALL have port win_ready, input, 1 bit: downstream consumes the window this cycle.
REQ-012 SHALL have port win_count, output, 8 bits: count of handed-off windows.

Function
REQ-013 SHALL treat a sample as accepted when in_valid && in_ready, and a window as handed off when win_valid && win_ready.
REQ-014 SHALL implement two states, FILL and HOLD; in FILL, in_ready = 1 and win_valid = 0.
REQ-015 SHALL, in FILL, write each accepted sample into slot idx (3-bit), then increment idx, leaving all other slots unchanged.
REQ-016 SHALL, on acceptance with idx = 7, move to HOLD and assert win_valid from the next cycle; this is 1-cycle latency from the last sample to window-valid.
REQ-017 SHALL, in HOLD, keep n0..n7 and win_valid stable until handoff, with in_ready = win_ready combinationally.
REQ-018 SHALL, on handoff with a simultaneous accepted sample, write that sample to n0, set idx = 1, and move to FILL, with no bubble.
REQ-019 SHALL, on handoff without an input sample, set idx = 0 and move to FILL.
REQ-020 SHALL increment win_count by 1 on each handoff, wrapping from 255 to 0.
REQ-021 SHALL give clear priority over all other events: idx = 0, state FILL, win_valid = 0, in_ready = 0 in that cycle, win_count unchanged, slot data retained, and any handoff or sample in that cycle ignored.
REQ-022 SHALL pass samples bit-exact, with no sign manipulation; sign extension is the adder's job.

Reset
REQ-023 SHALL, while rst_n = 0 at a clock edge, set n0..n7 = 0, win_valid = 0, win_count = 0, idx = 0, and state FILL.
REQ-024 SHALL drive in_ready = 0 during reset and return it to 1 on the first cycle after reset deasserts.
REQ-025 SHALL, on reset mid-FILL or mid-HOLD, discard the partial or held window without counting it.

Structure
REQ-026 SHALL place W, N, the FILL/HOLD state encoding, and the win_count width in a shared package used by the adder and its bench.
REQ-027 SHALL be a single module with no sub-module; the slot bank is N registers addressed by idx.

Verification
REQ-028 SHALL cover: eight accepted 0xFFF samples with win_ready = 1 -> n0..n7 = 0xFFF, win_valid high for 1 cycle, adder sum = 15'h7FF8 (-8), win_count = 1.
REQ-029 SHALL cover: eight 0x7FF samples, then eight 0x800 samples, back-to-back -> windows of all 0x7FF (sum 0x3FF8) then all 0x800 (sum 0x4000), with in_ready continuously high.
REQ-030 SHALL cover: alternating 0x001/0xFFF samples with win_ready held low for 5 cycles after the window completes -> in_ready = 0 for those cycles, n0..n7 stable, sum 0, handoff on cycle 6.
REQ-031 SHALL cover: three 0x123 samples, then clear, then eight 0x001 samples -> the window is all 0x001 (sum 8), and win_count is unaffected by the clear.
REQ-032 SHALL cover: rst_n low during HOLD -> next cycle win_valid = 0, n0..n7 = 0, win_count = 0; the next eight samples form a fresh window.
REQ-033 SHALL cover: 256 handoffs -> win_count wraps to 0 after 255.
